// File: rtl/escape_parser_pkg.sv
// Shared types for the terminal byte-stream parser: command codes, the
// parameter bundle handed to the text-edit stage, parser states and the
// C0 control bytes that steer escape handling.
package escape_parser_pkg;

  // Physical Pn slots carried in Param_t; the parser may retain fewer.
  localparam int unsigned PN_SLOTS = 4;

  typedef enum logic [3:0] {
    INPUT,
    CR,
    LF,
    BS,
    HT,
    CUU,
    CUD,
    CUF,
    CUB,
    CUP,
    ED,
    EL,
    SGR,
    RESET
  } CommandsType;

  typedef struct packed {
    logic [7:0]                Pchar;
    logic [PN_SLOTS-1:0][7:0]  Pn;
    logic [2:0]                Pcount;
  } Param_t;

  typedef enum logic [2:0] {
    ST_GROUND,
    ST_ESCAPE,
    ST_CSI_ENTRY,
    ST_CSI_PARAM,
    ST_CSI_IGNORE
  } parse_state_t;

  localparam logic [7:0] ESC = 8'h1B;
  localparam logic [7:0] CAN = 8'h18;
  localparam logic [7:0] SUB = 8'h1A;

  function automatic logic is_final(input logic [7:0] b);
    return (b >= 8'h40) && (b <= 8'h7E);
  endfunction

  function automatic logic is_digit(input logic [7:0] b);
    return (b >= 8'h30) && (b <= 8'h39);
  endfunction

  // Private markers (< = > ?) and intermediates send a CSI to the ignore state.
  function automatic logic is_csi_reject(input logic [7:0] b);
    return ((b >= 8'h3C) && (b <= 8'h3F)) || ((b >= 8'h20) && (b <= 8'h2F));
  endfunction

  // Final bytes the edit stage understands; anything else is dropped.
  function automatic logic csi_known(input logic [7:0] b);
    case (b)
      8'h41, 8'h42, 8'h43, 8'h44, 8'h48, 8'h66, 8'h4A, 8'h4B, 8'h6D: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic CommandsType csi_cmd(input logic [7:0] b);
    case (b)
      8'h41:        return CUU;   // A
      8'h42:        return CUD;   // B
      8'h43:        return CUF;   // C
      8'h44:        return CUB;   // D
      8'h48, 8'h66: return CUP;   // H, f
      8'h4A:        return ED;    // J
      8'h4B:        return EL;    // K
      default:      return SGR;   // m
    endcase
  endfunction

endpackage

// File: rtl/escape_parser_csi_param_acc.sv
// CSI numeric parameter accumulator: decimal digits build acc (saturating at
// 255), store moves acc into the next Pn slot, clear wipes everything.
// Latency: state updates on the strobe edge; *_d ports expose the post-edge
// values so the caller can latch them in the same cycle. No backpressure.
// Ports: clk/rst_n, clr/digit_vld/digit/store strobes, pn_d/pcount_d out.
module csi_param_acc
  import escape_parser_pkg::*;
#(
  parameter int unsigned MAX_PARAMS = PN_SLOTS
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clr,
  input  logic                     digit_vld,
  input  logic [3:0]               digit,
  input  logic                     store,
  output logic [PN_SLOTS-1:0][7:0] pn_d,
  output logic [2:0]               pcount_d
);

  logic [7:0]               acc_q, acc_d;
  logic [PN_SLOTS-1:0][7:0] pn_q;
  logic [2:0]               pcount_q;
  logic [11:0]              prod;

  always_comb begin
    acc_d    = acc_q;
    pn_d     = pn_q;
    pcount_d = pcount_q;
    // 255*10+9 = 2559 still fits in 12 bits, so saturation is a single compare.
    prod     = ({4'd0, acc_q} * 12'd10) + {8'd0, digit};

    if (clr) begin
      acc_d    = '0;
      pn_d     = '0;
      pcount_d = '0;
    end else if (store) begin
      // Parameters past MAX_PARAMS still advance the count up to its cap
      // but never land in a slot.
      for (int i = 0; i < int'(PN_SLOTS); i++) begin
        if ((pcount_q == 3'(i)) && (i < int'(MAX_PARAMS))) begin
          pn_d[i] = acc_q;
        end
      end
      if (pcount_q < 3'(MAX_PARAMS)) begin
        pcount_d = pcount_q + 3'd1;
      end
      acc_d = '0;
    end else if (digit_vld) begin
      acc_d = (prod > 12'd255) ? 8'hFF : prod[7:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q    <= '0;
      pn_q     <= '0;
      pcount_q <= '0;
    end else begin
      acc_q    <= acc_d;
      pn_q     <= pn_d;
      pcount_q <= pcount_d;
    end
  end

endmodule

// File: rtl/escape_parser.sv
// Terminal byte-stream decoder: printable/C0 bytes and ESC/CSI sequences in,
// one command at a time out to the text-edit stage.
// Latency: command completed by byte accepted at edge N pulses commandReady
// during cycle N+1; non-command bytes are taken back-to-back.
// Backpressure: dataReady = !editBusy && !pending (forced low in reset).
// Ports: clk, rst (async active-low), dataIn/dataValid/dataReady byte
// intake, editBusy stall, commandReady/commandType/param command output.
module escape_parser
  import escape_parser_pkg::*;
#(
  parameter int unsigned MAX_PARAMS = PN_SLOTS  // must not exceed PN_SLOTS
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  dataIn,
  input  logic        dataValid,
  output logic        dataReady,
  input  logic        editBusy,
  output logic        commandReady,
  output CommandsType commandType,
  output Param_t      param
);

  parse_state_t state_q, state_d;
  logic         pending_q, pending_d;
  CommandsType  cmd_type_q, cmd_type_d;
  Param_t       param_q, param_d;

  logic                     accept;
  logic                     acc_clr, acc_digit, acc_store;
  logic [PN_SLOTS-1:0][7:0] pn_nxt;
  logic [2:0]               pcount_nxt;
  logic                     emit, emit_csi;
  CommandsType              emit_type;

  // The pending flag doubles as the commandReady pulse and blocks intake for
  // that one cycle so the consumer has time to raise editBusy.
  assign dataReady    = rst && !editBusy && !pending_q;
  assign accept       = dataValid && dataReady;
  assign commandReady = pending_q;
  assign commandType  = cmd_type_q;
  assign param        = param_q;

  csi_param_acc #(
    .MAX_PARAMS (MAX_PARAMS)
  ) u_acc (
    .clk       (clk),
    .rst_n     (rst),
    .clr       (acc_clr),
    .digit_vld (acc_digit),
    .digit     (dataIn[3:0]),
    .store     (acc_store),
    .pn_d      (pn_nxt),
    .pcount_d  (pcount_nxt)
  );

  always_comb begin
    state_d    = state_q;
    cmd_type_d = cmd_type_q;
    param_d    = param_q;
    acc_clr    = 1'b0;
    acc_digit  = 1'b0;
    acc_store  = 1'b0;
    emit       = 1'b0;
    emit_csi   = 1'b0;
    emit_type  = INPUT;

    if (accept) begin
      case (state_q)
        ST_GROUND: begin
          if ((dataIn >= 8'h20) && (dataIn <= 8'h7E)) begin
            emit      = 1'b1;
            emit_type = INPUT;
          end else begin
            case (dataIn)
              8'h0D:               begin emit = 1'b1; emit_type = CR; end
              8'h0A, 8'h0B, 8'h0C: begin emit = 1'b1; emit_type = LF; end
              8'h08:               begin emit = 1'b1; emit_type = BS; end
              8'h09:               begin emit = 1'b1; emit_type = HT; end
              ESC:                 state_d = ST_ESCAPE;
              default:             ;
            endcase
          end
        end

        ST_ESCAPE: begin
          if (dataIn == 8'h5B) begin
            state_d = ST_CSI_ENTRY;
            acc_clr = 1'b1;
          end else if (dataIn == 8'h63) begin
            emit      = 1'b1;
            emit_type = RESET;
            state_d   = ST_GROUND;
          end else if (dataIn != ESC) begin
            state_d = ST_GROUND;
          end
        end

        ST_CSI_ENTRY, ST_CSI_PARAM: begin
          if ((dataIn == CAN) || (dataIn == SUB)) begin
            state_d = ST_GROUND;
          end else if (dataIn == ESC) begin
            state_d = ST_ESCAPE;
          end else if (dataIn < 8'h20) begin
            // stray C0 inside a sequence is swallowed
          end else if (is_digit(dataIn)) begin
            acc_digit = 1'b1;
            state_d   = ST_CSI_PARAM;
          end else if (dataIn == 8'h3B) begin
            acc_store = 1'b1;
            state_d   = ST_CSI_PARAM;
          end else if (is_csi_reject(dataIn)) begin
            state_d = ST_CSI_IGNORE;
          end else if (is_final(dataIn)) begin
            // CsiParam means a digit or ';' was seen, so acc holds a real value.
            acc_store = (state_q == ST_CSI_PARAM);
            if (csi_known(dataIn)) begin
              emit      = 1'b1;
              emit_csi  = 1'b1;
              emit_type = csi_cmd(dataIn);
            end
            state_d = ST_GROUND;
          end
        end

        ST_CSI_IGNORE: begin
          if ((dataIn == CAN) || (dataIn == SUB) || is_final(dataIn)) begin
            state_d = ST_GROUND;
          end else if (dataIn == ESC) begin
            state_d = ST_ESCAPE;
          end
        end

        default: state_d = ST_GROUND;
      endcase
    end

    pending_d = emit;
    if (emit) begin
      cmd_type_d   = emit_type;
      param_d.Pchar = dataIn;
      // Take the accumulator's post-edge view so the final store is included.
      param_d.Pn     = emit_csi ? pn_nxt : '0;
      param_d.Pcount = emit_csi ? pcount_nxt : 3'd0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_GROUND;
      pending_q  <= 1'b0;
      cmd_type_q <= INPUT;
      param_q    <= '0;
    end else begin
      state_q    <= state_d;
      pending_q  <= pending_d;
      cmd_type_q <= cmd_type_d;
      param_q    <= param_d;
    end
  end

endmodule
